act_unit_pipe: RTL and testbench

Multi-mode, lane-parallel activation stage for the vector engine; the parametrised successor to the single-mode ReLU stage. Applies identity, ReLU, leaky ReLU (arithmetic right shift) or clipped ReLU to BUS_NUM signed fixed-point lanes through a 2-stage pipeline with per-lane valid masks and valid/ready backpressure. Configuration changes are applied only on a drained pipeline, so every beat is processed under exactly one configuration.

---
 rtl/act_unit_pipe_if.sv | 13 +
 rtl/act_unit_pipe.sv | 140 ++++++++++++++
 tb/tb_act_unit_pipe.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/act_unit_pipe_if.sv
// Lane-parallel beat bus: packed signed lanes, per-lane valid mask, and ready.
// The producer side uses the master modport, the consumer side the slave modport.
interface act_unit_pipe_if #(
    parameter int BUS_NUM          = 16,
    parameter int FIXED_DATA_WIDTH = 8
);
    logic [BUS_NUM*FIXED_DATA_WIDTH-1:0] fixed_data;
    logic [BUS_NUM-1:0]                  fixed_data_vld;
    logic                                rdy;

    modport master (output fixed_data, output fixed_data_vld, input rdy);
    modport slave  (input fixed_data, input fixed_data_vld, output rdy);
endinterface

// File: rtl/act_unit_pipe.sv
// Two-stage lane-parallel activation stage (identity / ReLU / leaky / clipped ReLU)
// with valid/ready backpressure and configuration applied only on a drained pipeline.
//
// state | meaning
// RUN   | accepting beats; a config load on an empty pipe takes effect at once
// DRAIN | config pending; input blocked until both stages have emptied
module act_unit_pipe #(
    parameter int BUS_NUM          = 16,
    parameter int FIXED_DATA_WIDTH = 8,
    parameter int SCALA_POS_WIDTH  = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_load,
    input  logic [1:0]                  cfg_mode,
    input  logic [SCALA_POS_WIDTH-1:0]  cfg_shift,
    input  logic [FIXED_DATA_WIDTH-1:0] cfg_clip,
    output logic                        cfg_busy,
    act_unit_pipe_if.slave              in_bus,
    act_unit_pipe_if.master             out_bus
);

    localparam int W = FIXED_DATA_WIDTH;
    localparam logic [W-1:0] CLIP_MAX = {1'b0, {(W-1){1'b1}}};

    typedef enum logic {RUN, DRAIN} state_t;

    state_t state, state_nxt;
    logic   apply_cfg;

    logic [1:0]                 act_mode, shd_mode, new_mode;
    logic [SCALA_POS_WIDTH-1:0] act_shift, shd_shift, new_shift;
    logic [W-1:0]               act_clip, shd_clip, new_clip;

    logic [BUS_NUM*W-1:0] lane_res, s1_data;
    logic [BUS_NUM-1:0]   s1_vld;
    logic                 s1_v, s2_v, s1_load, s2_load, in_fire;

    function automatic logic [W-1:0] act_lane(
        input logic signed [W-1:0]      x,
        input logic [1:0]               mode,
        input logic [SCALA_POS_WIDTH-1:0] sh,
        input logic signed [W-1:0]      clip
    );
        logic signed [W-1:0] clip_eff;
        clip_eff = clip[W-1] ? '0 : clip;
        case (mode)
            2'd0:    return x;
            2'd1:    return x[W-1] ? '0 : x;
            2'd2:    return x[W-1] ? (x >>> sh) : x;
            default: return x[W-1] ? '0 : ((x > clip_eff) ? clip_eff : x);
        endcase
    endfunction

    always_comb begin
        lane_res = '0;
        for (int i = 0; i < BUS_NUM; i++) begin
            if (in_bus.fixed_data_vld[i]) begin
                lane_res[i*W +: W] = act_lane(in_bus.fixed_data[i*W +: W],
                                              act_mode, act_shift, act_clip);
            end
        end
    end

    assign s1_v    = |s1_vld;
    assign s2_v    = |out_bus.fixed_data_vld;
    assign s2_load = !s2_v || out_bus.rdy;
    // Stage 1 may also fill while stage 2 is stalled, as long as it is empty itself.
    assign s1_load = s2_load || !s1_v;

    assign in_bus.rdy = (state == RUN) && !cfg_load && s1_load;
    assign in_fire    = (|in_bus.fixed_data_vld) && in_bus.rdy;
    assign cfg_busy   = (state == DRAIN);

    // A load in the same cycle as the drain completes must win over the older shadow.
    assign new_mode  = cfg_load ? cfg_mode  : shd_mode;
    assign new_shift = cfg_load ? cfg_shift : shd_shift;
    assign new_clip  = cfg_load ? cfg_clip  : shd_clip;

    always_comb begin
        state_nxt = state;
        apply_cfg = 1'b0;
        case (state)
            RUN: begin
                if (cfg_load) begin
                    if (!s1_v && !s2_v) apply_cfg = 1'b1;
                    else                state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!s1_v && s2_load) begin
                    apply_cfg = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            shd_mode  <= 2'd1;
            shd_shift <= '0;
            shd_clip  <= CLIP_MAX;
            act_mode  <= 2'd1;
            act_shift <= '0;
            act_clip  <= CLIP_MAX;
        end else begin
            state     <= state_nxt;
            shd_mode  <= new_mode;
            shd_shift <= new_shift;
            shd_clip  <= new_clip;
            if (apply_cfg) begin
                act_mode  <= new_mode;
                act_shift <= new_shift;
                act_clip  <= new_clip;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data                <= '0;
            s1_vld                 <= '0;
            out_bus.fixed_data     <= '0;
            out_bus.fixed_data_vld <= '0;
        end else begin
            if (s1_load) begin
                s1_data <= in_fire ? lane_res : '0;
                s1_vld  <= in_fire ? in_bus.fixed_data_vld : '0;
            end
            if (s2_load) begin
                out_bus.fixed_data     <= s1_data;
                out_bus.fixed_data_vld <= s1_vld;
            end
        end
    end

endmodule

// File: tb/tb_act_unit_pipe.sv
// Self-checking bench for act_unit_pipe: directed scenarios plus randomized traffic,
// scored against a lane-arithmetic reference model and a FIFO of expected beats.
module tb_act_unit_pipe;

    localparam int BN = 4;
    localparam int W  = 8;
    localparam int SW = 5;
    localparam int DW = BN * W;

    logic clk, rst_n;
    logic cfg_load;
    logic [1:0] cfg_mode;
    logic [SW-1:0] cfg_shift;
    logic [W-1:0] cfg_clip;
    logic cfg_busy;

    act_unit_pipe_if #(.BUS_NUM(BN), .FIXED_DATA_WIDTH(W)) in_bus ();
    act_unit_pipe_if #(.BUS_NUM(BN), .FIXED_DATA_WIDTH(W)) out_bus ();

    act_unit_pipe #(.BUS_NUM(BN), .FIXED_DATA_WIDTH(W), .SCALA_POS_WIDTH(SW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_load (cfg_load),
        .cfg_mode (cfg_mode),
        .cfg_shift(cfg_shift),
        .cfg_clip (cfg_clip),
        .cfg_busy (cfg_busy),
        .in_bus   (in_bus),
        .out_bus  (out_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int mcfg_mode, mcfg_shift, mcfg_clip;
    logic [DW-1:0] exp_d[$];
    logic [BN-1:0] exp_v[$];
    int   n_out;
    bit   chk_rdy;
    bit   prev_hold;
    logic [DW-1:0] prev_d;
    logic [BN-1:0] prev_v;

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: each lane evaluated as an integer from the activation definitions.
    function automatic logic [DW-1:0] ref_out(input logic [DW-1:0] d, input logic [BN-1:0] v,
                                              input int mode, input int sh, input int clip);
        logic [DW-1:0] r;
        logic [W-1:0] lane;
        int x, y, c, dv;
        r = '0;
        for (int i = 0; i < BN; i++) begin
            lane = d[i*W +: W];
            x = $signed(lane);
            y = 0;
            if (v[i]) begin
                case (mode)
                    0: y = x;
                    1: y = (x < 0) ? 0 : x;
                    2: begin
                        if (x >= 0)          y = x;
                        else if (sh >= W-1)  y = -1;
                        else begin
                            dv = 1 << sh;
                            y = (x - (dv - 1)) / dv;
                        end
                    end
                    default: begin
                        c = (clip < 0) ? 0 : clip;
                        y = (x < 0) ? 0 : ((x < c) ? x : c);
                    end
                endcase
            end
            r[i*W +: W] = y[W-1:0];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk(64'(out_bus.fixed_data), 64'(prev_d), "hold_data");
                chk(64'(out_bus.fixed_data_vld), 64'(prev_v), "hold_mask");
            end
            if (chk_rdy)
                chk(64'(in_bus.rdy), 64'((exp_d.size() < 2) || out_bus.rdy), "in_rdy_occupancy");
            if ((|out_bus.fixed_data_vld) && out_bus.rdy) begin
                chk(64'(exp_d.size() > 0), 64'd1, "sb_beat_expected");
                if (exp_d.size() > 0) begin
                    chk(64'(out_bus.fixed_data), 64'(exp_d.pop_front()), "sb_data");
                    chk(64'(out_bus.fixed_data_vld), 64'(exp_v.pop_front()), "sb_mask");
                    n_out++;
                end
            end
            if ((|in_bus.fixed_data_vld) && in_bus.rdy) begin
                exp_d.push_back(ref_out(in_bus.fixed_data, in_bus.fixed_data_vld,
                                        mcfg_mode, mcfg_shift, mcfg_clip));
                exp_v.push_back(in_bus.fixed_data_vld);
            end
            prev_hold = (|out_bus.fixed_data_vld) && !out_bus.rdy;
            prev_d    = out_bus.fixed_data;
            prev_v    = out_bus.fixed_data_vld;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_model_defaults();
        mcfg_mode  = 1;
        mcfg_shift = 0;
        mcfg_clip  = 127;
    endtask

    task automatic do_cfg(input int mode, input int sh, input logic [W-1:0] clip);
        cfg_load  = 1'b1;
        cfg_mode  = 2'(mode);
        cfg_shift = SW'(sh);
        cfg_clip  = clip;
        mcfg_mode = mode;
        mcfg_shift = sh;
        mcfg_clip = $signed(clip);
        tick();
        cfg_load = 1'b0;
    endtask

    // Present a beat until accepted; returns 1 ns after the accepting edge.
    task automatic send(input logic [DW-1:0] d, input logic [BN-1:0] v);
        int k;
        k = 0;
        in_bus.fixed_data     = d;
        in_bus.fixed_data_vld = v;
        @(negedge clk);
        while (!in_bus.rdy && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk(64'(k < 40), 64'd1, "send_accept_timeout");
        @(posedge clk);
        #1;
        in_bus.fixed_data_vld = '0;
        in_bus.fixed_data     = '0;
    endtask

    task automatic send_and_check(input logic [DW-1:0] d, input logic [BN-1:0] v,
                                  input logic [DW-1:0] ed, input string tag);
        send(d, v);
        chk(64'(out_bus.fixed_data_vld), 64'd0, {tag, "_latency"});
        tick();
        chk(64'(out_bus.fixed_data), 64'(ed), {tag, "_data"});
        chk(64'(out_bus.fixed_data_vld), 64'(v), {tag, "_mask"});
    endtask

    logic [DW-1:0] beat_data[10];
    int n_acc;
    bit saw_stall;

    initial begin
        rst_n = 1'b0;
        cfg_load = 1'b0;
        cfg_mode = '0;
        cfg_shift = '0;
        cfg_clip = '0;
        in_bus.fixed_data = '0;
        in_bus.fixed_data_vld = '0;
        out_bus.rdy = 1'b1;
        chk_rdy = 1'b0;
        n_out = 0;
        set_model_defaults();
        #1;
        chk(64'(out_bus.fixed_data), 64'd0, "reset_data");
        chk(64'(out_bus.fixed_data_vld), 64'd0, "reset_mask");
        chk(64'(cfg_busy), 64'd0, "reset_busy");
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk(64'(in_bus.rdy), 64'd1, "reset_in_rdy");
        tick();

        // Reset-default ReLU
        send_and_check(32'h807FFD05, 4'hF, 32'h007F0005, "relu_default");
        // Leaky shift 2, then shift 31
        do_cfg(2, 2, 8'h7F);
        send_and_check(32'h0780FFF8, 4'hF, 32'h07E0FFFE, "leaky_s2");
        do_cfg(2, 31, 8'h7F);
        send_and_check(32'hFBFBFBFB, 4'hF, 32'hFFFFFFFF, "leaky_s31");
        // Clipped ReLU, positive clip then negative clip
        do_cfg(3, 0, 8'd6);
        send_and_check(32'h640603FC, 4'hF, 32'h06060300, "clip6");
        do_cfg(3, 0, 8'hFE);
        send_and_check(32'h640603FC, 4'hF, 32'h00000000, "clip_neg");
        // Sparse mask under ReLU
        do_cfg(1, 0, 8'h7F);
        send_and_check(32'h09FF0904, 4'h5, 32'h00000004, "sparse");
        tick();

        // Backpressure: 10 beats, out_rdy low for 4 cycles mid-stream
        foreach (beat_data[j]) beat_data[j] = $urandom;
        n_acc = 0;
        n_out = 0;
        saw_stall = 1'b0;
        chk_rdy = 1'b1;
        for (int c = 0; c < 60 && n_acc < 10; c++) begin
            out_bus.rdy = !(c >= 3 && c < 7);
            in_bus.fixed_data = beat_data[n_acc];
            in_bus.fixed_data_vld = 4'hF;
            @(negedge clk);
            if (!in_bus.rdy) saw_stall = 1'b1;
            if (in_bus.rdy) n_acc++;
            tick();
        end
        in_bus.fixed_data_vld = '0;
        out_bus.rdy = 1'b1;
        for (int c = 0; c < 20 && n_out < 10; c++) tick();
        chk_rdy = 1'b0;
        chk(64'(n_acc), 64'd10, "bp_accepted");
        chk(64'(n_out), 64'd10, "bp_delivered");
        chk(64'(saw_stall), 64'd1, "bp_in_rdy_fell");

        // Config change with two beats in flight
        out_bus.rdy = 1'b0;
        send(32'h03FF14F9, 4'hF);
        send(32'h11223344, 4'hF);
        chk(64'(out_bus.fixed_data), 64'h03001400, "inflight_old_mode");
        in_bus.fixed_data = 32'hF9F9F9F9;
        in_bus.fixed_data_vld = 4'hF;
        cfg_load = 1'b1;
        cfg_mode = 2'd0;
        cfg_shift = '0;
        cfg_clip = 8'h7F;
        #1;
        chk(64'(in_bus.rdy), 64'd0, "cfg_load_blocks_input");
        mcfg_mode = 0;
        mcfg_shift = 0;
        mcfg_clip = 127;
        tick();
        cfg_load = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk(64'(cfg_busy), 64'd1, "drain_busy");
            chk(64'(in_bus.rdy), 64'd0, "drain_in_rdy");
            tick();
        end
        out_bus.rdy = 1'b1;
        send_and_check(32'hF9F9F9F9, 4'hF, 32'hF9F9F9F9, "identity_after_drain");
        chk(64'(cfg_busy), 64'd0, "busy_cleared");

        // Randomized traffic with occasional config loads
        for (int c = 0; c < 400; c++) begin
            in_bus.fixed_data = $urandom;
            in_bus.fixed_data_vld = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            out_bus.rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                do_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), 8'($urandom));
            end else begin
                tick();
            end
        end
        in_bus.fixed_data_vld = '0;
        out_bus.rdy = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        chk(64'(exp_d.size()), 64'd0, "random_drained");

        // Reset mid-stream with a pending config
        do_cfg(1, 0, 8'h7F);
        out_bus.rdy = 1'b0;
        send(32'h01020304, 4'hF);
        send(32'h05060708, 4'hF);
        cfg_load = 1'b1;
        cfg_mode = 2'd0;
        tick();
        cfg_load = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk(64'(out_bus.fixed_data), 64'd0, "midreset_data");
        chk(64'(out_bus.fixed_data_vld), 64'd0, "midreset_mask");
        chk(64'(cfg_busy), 64'd0, "midreset_busy");
        exp_d.delete();
        exp_v.delete();
        set_model_defaults();
        tick();
        tick();
        rst_n = 1'b1;
        out_bus.rdy = 1'b1;
        tick();
        send_and_check(32'hFDFDFD05, 4'hF, 32'h00000005, "relu_after_reset");
        tick();
        chk(64'(exp_d.size()), 64'd0, "final_drained");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
